commit_queue: RTL and testbench

COMMIT_QUEUE -- requirements
Module: commit_queue

---
 rtl/commit_queue.sv | 134 +++++++++++++
 tb/tb_commit_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_queue.sv
// Commit queue: per-FU 2-entry result FIFOs drained into COMMIT_WIDTH ROB
// commit slots each cycle by a rotating-priority arbiter.
module commit_queue #(
  parameter int unsigned FU_NUM       = 4,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned PREG_BITS    = 6,
  parameter int unsigned DATA_BITS    = 64
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic [FU_NUM-1:0]                        fu_valid,
  output logic [FU_NUM-1:0]                        fu_ready,
  input  logic [FU_NUM-1:0][PREG_BITS-1:0]         fu_dst,
  input  logic [FU_NUM-1:0][DATA_BITS-1:0]         fu_data,
  output logic [COMMIT_WIDTH-1:0]                  commit_valid,
  output logic [COMMIT_WIDTH-1:0][PREG_BITS-1:0]   commit_dst,
  output logic [COMMIT_WIDTH-1:0][DATA_BITS-1:0]   commit_data,
  output logic [31:0]                              commit_count
);

  localparam int unsigned RR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  typedef struct packed {
    logic [PREG_BITS-1:0] dst;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  entry_t                                 mem_q [FU_NUM][2];
  logic [1:0]                             cnt_q [FU_NUM];
  logic [1:0]                             cnt_d [FU_NUM];
  logic [FU_NUM-1:0]                      head_q, head_d;
  logic [FU_NUM-1:0]                      ready_q, ready_d;
  logic [FU_NUM-1:0]                      push, taken, tail;
  logic [RR_W-1:0]                        rr_q, rr_d;
  logic [COMMIT_WIDTH-1:0]                grant_vld;
  logic [COMMIT_WIDTH-1:0]                valid_q, valid_d;
  logic [COMMIT_WIDTH-1:0][PREG_BITS-1:0] dst_q, dst_d;
  logic [COMMIT_WIDTH-1:0][DATA_BITS-1:0] data_q, data_d;
  logic [31:0]                            count_q, count_d;
  logic [RR_W-1:0]                        pick, last, p;
  logic                                   found, any;

  // Rotating arbiter: slot k takes the k-th non-empty FIFO counting from rr.
  always_comb begin
    taken     = '0;
    grant_vld = '0;
    dst_d     = '0;
    data_d    = '0;
    last      = rr_q;
    any       = 1'b0;
    found     = 1'b0;
    pick      = '0;
    p         = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      found = 1'b0;
      pick  = '0;
      for (int j = 0; j < FU_NUM; j++) begin
        p = RR_W'((32'(rr_q) + 32'(j)) % FU_NUM);
        if (!found && (cnt_q[p] != 2'd0) && !taken[p]) begin
          found = 1'b1;
          pick  = p;
        end
      end
      if (found) begin
        taken[pick]  = 1'b1;
        grant_vld[k] = 1'b1;
        dst_d[k]     = mem_q[pick][head_q[pick]].dst;
        data_d[k]    = mem_q[pick][head_q[pick]].data;
        last         = pick;
        any          = 1'b1;
      end
    end
  end

  // FIFO bookkeeping, pointer rotation and flush.
  always_comb begin
    push    = '0;
    tail    = '0;
    head_d  = head_q;
    ready_d = ready_q;
    valid_d = flush ? '0 : grant_vld;
    rr_d    = any ? RR_W'((32'(last) + 32'd1) % FU_NUM) : rr_q;
    count_d = count_q + 32'($countones(valid_d));
    for (int i = 0; i < FU_NUM; i++) begin
      push[i]   = fu_valid[i] & ready_q[i] & ~flush;
      tail[i]   = head_q[i] ^ cnt_q[i][0];
      cnt_d[i]  = cnt_q[i] + 2'(push[i]) - 2'(taken[i]);
      head_d[i] = head_q[i] ^ taken[i];
    end
    if (flush) begin
      for (int i = 0; i < FU_NUM; i++) cnt_d[i] = 2'd0;
      head_d = '0;
      rr_d   = '0;
    end
    for (int i = 0; i < FU_NUM; i++) ready_d[i] = ~cnt_d[i][1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FU_NUM; i++) cnt_q[i] <= 2'd0;
      head_q  <= '0;
      ready_q <= '1;
      rr_q    <= '0;
      valid_q <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) cnt_q[i] <= cnt_d[i];
      head_q  <= head_d;
      ready_q <= ready_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Result storage needs no reset; occupancy counters gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_NUM; i++) begin
      if (push[i]) mem_q[i][tail[i]] <= {fu_dst[i], fu_data[i]};
    end
  end

  assign fu_ready     = ready_q;
  assign commit_valid = valid_q;
  assign commit_dst   = dst_q;
  assign commit_data  = data_q;
  assign commit_count = count_q;

endmodule

// File: tb/tb_commit_queue.sv
// Bench for commit_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the commit rules.
module tb_commit_queue;

  localparam int unsigned FU = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned PB = 6;
  localparam int unsigned DB = 64;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   flush = 1'b0;
  logic [FU-1:0]          fu_valid = '0;
  logic [FU-1:0]          fu_ready;
  logic [FU-1:0][PB-1:0]  fu_dst = '0;
  logic [FU-1:0][DB-1:0]  fu_data = '0;
  logic [CW-1:0]          commit_valid;
  logic [CW-1:0][PB-1:0]  commit_dst;
  logic [CW-1:0][DB-1:0]  commit_data;
  logic [31:0]            commit_count;

  commit_queue #(
    .FU_NUM(FU), .COMMIT_WIDTH(CW), .PREG_BITS(PB), .DATA_BITS(DB)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_dst(fu_dst), .fu_data(fu_data),
    .commit_valid(commit_valid), .commit_dst(commit_dst), .commit_data(commit_data),
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PB-1:0] dst;
    logic [DB-1:0] data;
  } ent_t;

  // Reference model: one queue per port plus expected output slots.
  ent_t          mq [FU][$];
  int            m_rr;
  logic [CW-1:0] m_valid;
  ent_t          m_slot [CW];
  logic [31:0]   m_count;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < FU; i++) mq[i].delete();
    m_rr    = 0;
    m_valid = '0;
    m_count = '0;
  endtask

  // Apply one clock edge's worth of the commit rules to the model.
  task automatic model_edge();
    int sz [FU];
    int ng;
    int last;
    int p;
    if (reset) begin
      model_clear();
      return;
    end
    if (flush) begin
      for (int i = 0; i < FU; i++) mq[i].delete();
      m_valid = '0;
      m_rr    = 0;
      return;
    end
    for (int i = 0; i < FU; i++) sz[i] = mq[i].size();
    m_valid = '0;
    ng      = 0;
    last    = -1;
    for (int j = 0; j < FU; j++) begin
      p = (m_rr + j) % FU;
      if (sz[p] > 0 && ng < CW) begin
        m_slot[ng]  = mq[p].pop_front();
        m_valid[ng] = 1'b1;
        ng++;
        last = p;
      end
    end
    for (int i = 0; i < FU; i++)
      if (fu_valid[i] && sz[i] < 2) mq[i].push_back({fu_dst[i], fu_data[i]});
    if (last >= 0) m_rr = (last + 1) % FU;
    m_count = m_count + 32'(ng);
  endtask

  task automatic compare_model();
    logic [FU-1:0] exp_rdy;
    for (int i = 0; i < FU; i++) exp_rdy[i] = (mq[i].size() < 2);
    check_eq("ready", 64'(fu_ready), 64'(exp_rdy));
    check_eq("valid", 64'(commit_valid), 64'(m_valid));
    for (int k = 0; k < CW; k++) begin
      if (m_valid[k] && commit_valid[k]) begin
        check_eq("dst", 64'(commit_dst[k]), 64'(m_slot[k].dst));
        check_eq("data", commit_data[k], m_slot[k].data);
      end
    end
    check_eq("count", 64'(commit_count), 64'(m_count));
  endtask

  // One clock: outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare_model();
  endtask

  // Reset raised between edges; outputs must clear before the next edge.
  task automatic do_reset();
    fu_valid = '0;
    flush    = 1'b0;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_eq("rst_valid", 64'(commit_valid), 64'd0);
    check_eq("rst_dst", 64'(commit_dst), 64'd0);
    check_eq("rst_data", 64'(commit_data[0] | commit_data[1]), 64'd0);
    check_eq("rst_count", 64'(commit_count), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    check_eq("rst_ready", 64'(fu_ready), 64'({FU{1'b1}}));
  endtask

  int            seq [FU];
  int            tally [FU];
  int            nxt1;
  logic          low1;
  logic [FU-1:0] rdy;

  initial begin
    // Single result on port 2.
    do_reset();
    fu_valid    = 4'b0100;
    fu_dst[2]   = 6'h15;
    fu_data[2]  = 64'hDEAD;
    tick();
    fu_valid = '0;
    check_eq("t1_e0_valid", 64'(commit_valid), 64'd0);
    tick();
    check_eq("t1_valid", 64'(commit_valid), 64'b01);
    check_eq("t1_dst", 64'(commit_dst[0]), 64'h15);
    check_eq("t1_data", commit_data[0], 64'hDEAD);
    tick();
    check_eq("t1_idle", 64'(commit_valid), 64'd0);
    check_eq("t1_count", 64'(commit_count), 64'd1);

    // Four simultaneous results, then probe the rotation pointer.
    do_reset();
    fu_valid = '1;
    for (int i = 0; i < FU; i++) begin
      fu_dst[i]  = PB'(i + 1);
      fu_data[i] = 64'(100 + i);
    end
    tick();
    fu_valid = '0;
    tick();
    check_eq("t2_n_valid", 64'(commit_valid), 64'b11);
    check_eq("t2_n_dst0", 64'(commit_dst[0]), 64'd1);
    check_eq("t2_n_dst1", 64'(commit_dst[1]), 64'd2);
    tick();
    check_eq("t2_n1_valid", 64'(commit_valid), 64'b11);
    check_eq("t2_n1_dst0", 64'(commit_dst[0]), 64'd3);
    check_eq("t2_n1_dst1", 64'(commit_dst[1]), 64'd4);
    tick();
    fu_valid  = 4'b1010;
    fu_dst[1] = 6'h21;
    fu_dst[3] = 6'h23;
    tick();
    fu_valid = '0;
    tick();
    check_eq("t2_rr_dst0", 64'(commit_dst[0]), 64'h21);
    check_eq("t2_rr_dst1", 64'(commit_dst[1]), 64'h23);

    // All ports saturated: back-to-back fill of port 1 and grant fairness.
    do_reset();
    for (int i = 0; i < FU; i++) begin
      seq[i]   = 0;
      tally[i] = 0;
    end
    nxt1 = 0;
    low1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      fu_valid = (c < 14) ? '1 : '0;
      for (int i = 0; i < FU; i++) begin
        fu_dst[i]  = {2'(i), 4'(seq[i])};
        fu_data[i] = {32'(i), 32'(seq[i])};
      end
      rdy = fu_ready;
      if (c < 14 && !rdy[1]) low1 = 1'b1;
      tick();
      for (int i = 0; i < FU; i++) if (fu_valid[i] && rdy[i]) seq[i]++;
      for (int k = 0; k < CW; k++) begin
        if (commit_valid[k] && commit_dst[k][5:4] == 2'd1) begin
          check_eq("t3_p1_order", 64'(commit_dst[k][3:0]), 64'(4'(nxt1)));
          nxt1++;
        end
      end
      if (c >= 1 && c <= 8) begin
        check_eq("t4_slot0", 64'(commit_dst[0][5:4]), 64'(((c - 1) % 2) * 2));
        check_eq("t4_slot1", 64'(commit_dst[1][5:4]), 64'(((c - 1) % 2) * 2 + 1));
        for (int k = 0; k < CW; k++)
          if (commit_valid[k]) tally[commit_dst[k][5:4]]++;
      end
    end
    check_eq("t3_p1_noloss", 64'(nxt1), 64'(seq[1]));
    check_eq("t3_ready1_drop", 64'(low1), 64'd1);
    for (int i = 0; i < FU; i++) check_eq("t4_fair", 64'(tally[i]), 64'd4);

    // Flush with five buffered entries and a same-cycle push.
    do_reset();
    fu_valid = 4'b1111;
    tick();
    fu_valid = 4'b1101;
    tick();
    check_eq("t5_pre_count", 64'(commit_count), 64'd2);
    flush    = 1'b1;
    fu_valid = 4'b1111;
    tick();
    flush    = 1'b0;
    fu_valid = '0;
    check_eq("t5_valid", 64'(commit_valid), 64'd0);
    check_eq("t5_ready", 64'(fu_ready), 64'({FU{1'b1}}));
    check_eq("t5_count", 64'(commit_count), 64'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t5_idle_valid", 64'(commit_valid), 64'd0);
      check_eq("t5_idle_count", 64'(commit_count), 64'd2);
    end

    // Randomized traffic with occasional flush and a mid-burst reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fu_valid = FU'($urandom);
      for (int i = 0; i < FU; i++) begin
        fu_dst[i]  = PB'($urandom);
        fu_data[i] = {$urandom, $urandom};
      end
      flush = ($urandom_range(0, 39) == 0);
      if (c == 200) begin
        do_reset();
        check_eq("t6_no_pulse", 64'(commit_valid), 64'd0);
      end else begin
        tick();
      end
    end
    flush    = 1'b0;
    fu_valid = '0;
    for (int c = 0; c < 6; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
